// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two RAM requesters (panel, CPU), the block RAM and the arbiter.
// The arbiter connects through the slave modport; requesters and the RAM connect through master.
interface ram_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          p_req;
   logic          p_we;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata;
   logic          p_ack;
   logic [DW-1:0] p_rdata;

   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_ack;
   logic [DW-1:0] c_rdata;

   logic [DW-1:0] ram_I;
   logic [DW-1:0] ram_data_O;
   logic [AW-1:0] ram_address;
   logic          wren;
   logic          busy;
   logic          owner;

   modport slave (
      input  p_req, p_we, p_addr, p_wdata,
      input  c_req, c_we, c_addr, c_wdata,
      input  ram_I,
      output p_ack, p_rdata, c_ack, c_rdata,
      output ram_data_O, ram_address, wren, busy, owner
   );

   modport master (
      output p_req, p_we, p_addr, p_wdata,
      output c_req, c_we, c_addr, c_wdata,
      output ram_I,
      input  p_ack, p_rdata, c_ack, c_rdata,
      input  ram_data_O, ram_address, wren, busy, owner
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: serves the front panel and the CPU one transaction at a time,
// with fixed panel priority or round-robin, and returns a one-cycle ack to the winner.
module ram_port_arbiter #(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int RD_LAT     = 1,
   parameter int PANEL_PRIO = 1
) (
   input logic             CLK,
   input logic             RSTN,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

   localparam logic [1:0] LAT = 2'(RD_LAT);

   state_t        state, state_nxt;
   logic [1:0]    cnt, cnt_nxt;
   logic          rr_ptr, rr_nxt;
   logic          owner_q, owner_nxt;
   logic          wren_q, wren_nxt;
   logic          p_ack_q, p_ack_nxt;
   logic          c_ack_q, c_ack_nxt;
   logic [AW-1:0] addr_q, addr_nxt;
   logic [DW-1:0] wdata_q, wdata_nxt;
   logic [DW-1:0] p_rdata_q, p_rdata_nxt;
   logic [DW-1:0] c_rdata_q, c_rdata_nxt;

   logic          any_req;
   logic          grant_c;
   logic          grant_we;

   assign any_req = bus.p_req | bus.c_req;

   // rr_ptr = 1 means the CPU takes the next tie; a lone requester always wins.
   generate
      if (PANEL_PRIO != 0) begin : g_fixed
         assign grant_c = bus.c_req & ~bus.p_req;
      end else begin : g_rr
         assign grant_c = bus.c_req & (~bus.p_req | rr_ptr);
      end
   endgenerate

   assign grant_we = grant_c ? bus.c_we : bus.p_we;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rr_nxt      = rr_ptr;
      owner_nxt   = owner_q;
      wren_nxt    = 1'b0;
      p_ack_nxt   = 1'b0;
      c_ack_nxt   = 1'b0;
      addr_nxt    = addr_q;
      wdata_nxt   = wdata_q;
      p_rdata_nxt = p_rdata_q;
      c_rdata_nxt = c_rdata_q;

      case (state)
         IDLE: begin
            if (any_req) begin
               owner_nxt = grant_c;
               rr_nxt    = ~grant_c;
               addr_nxt  = grant_c ? bus.c_addr  : bus.p_addr;
               wdata_nxt = grant_c ? bus.c_wdata : bus.p_wdata;
               if (grant_we) begin
                  state_nxt = WR;
                  wren_nxt  = 1'b1;
               end else begin
                  state_nxt = RD;
                  cnt_nxt   = LAT;
               end
            end
         end
         WR: begin
            state_nxt = DONE;
            p_ack_nxt = ~owner_q;
            c_ack_nxt = owner_q;
         end
         RD: begin
            // cnt still holds the remaining latency; the last step captures ram_I.
            if (cnt == 2'd1) begin
               state_nxt = DONE;
               p_ack_nxt = ~owner_q;
               c_ack_nxt = owner_q;
               if (owner_q) c_rdata_nxt = bus.ram_I;
               else         p_rdata_nxt = bus.ram_I;
            end else begin
               cnt_nxt = cnt - 2'd1;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         rr_ptr    <= 1'b0;
         owner_q   <= 1'b0;
         wren_q    <= 1'b0;
         p_ack_q   <= 1'b0;
         c_ack_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         p_rdata_q <= '0;
         c_rdata_q <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rr_ptr    <= rr_nxt;
         owner_q   <= owner_nxt;
         wren_q    <= wren_nxt;
         p_ack_q   <= p_ack_nxt;
         c_ack_q   <= c_ack_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         p_rdata_q <= p_rdata_nxt;
         c_rdata_q <= c_rdata_nxt;
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.owner       = owner_q;
   assign bus.wren        = wren_q;
   assign bus.p_ack       = p_ack_q;
   assign bus.c_ack       = c_ack_q;
   assign bus.p_rdata     = p_rdata_q;
   assign bus.c_rdata     = c_rdata_q;
   assign bus.ram_address = addr_q;
   assign bus.ram_data_O  = wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: round-robin arbiter (dut_a) and panel-priority arbiter (dut_b) share stimulus,
// each with its own RAM model of two-cycle read latency.
module tb_ram_port_arbiter;
   localparam int AW     = 16;
   localparam int DW     = 16;
   localparam int RD_LAT = 2;

   logic CLK = 1'b0;
   logic RSTN;
   always #5 CLK = ~CLK;

   ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus_a ();
   ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

   ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PANEL_PRIO(0)) dut_a (
      .CLK (CLK), .RSTN (RSTN), .bus (bus_a)
   );
   ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PANEL_PRIO(1)) dut_b (
      .CLK (CLK), .RSTN (RSTN), .bus (bus_b)
   );

   assign bus_b.p_req   = bus_a.p_req;
   assign bus_b.p_we    = bus_a.p_we;
   assign bus_b.p_addr  = bus_a.p_addr;
   assign bus_b.p_wdata = bus_a.p_wdata;
   assign bus_b.c_req   = bus_a.c_req;
   assign bus_b.c_we    = bus_a.c_we;
   assign bus_b.c_addr  = bus_a.c_addr;
   assign bus_b.c_wdata = bus_a.c_wdata;

   logic [DW-1:0] mem_a [0:255];
   logic [DW-1:0] mem_b [0:255];
   logic          ld;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   // Registered read: address seen at edge E0+1, data sampled by the arbiter at E0+2.
   always @(posedge CLK) begin
      if (ld) begin
         mem_a[ld_addr[7:0]] <= ld_data;
         mem_b[ld_addr[7:0]] <= ld_data;
      end
      if (bus_a.wren) mem_a[bus_a.ram_address[7:0]] <= bus_a.ram_data_O;
      if (bus_b.wren) mem_b[bus_b.ram_address[7:0]] <= bus_b.ram_data_O;
      bus_a.ram_I <= mem_a[bus_a.ram_address[7:0]];
      bus_b.ram_I <= mem_b[bus_b.ram_address[7:0]];
   end

   int n_assert = 0;
   int n_fail   = 0;
   int n_pack   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RSTN          = 1'b0;
      ld            = 1'b0;
      ld_addr       = '0;
      ld_data       = '0;
      bus_a.p_req   = 1'b0;
      bus_a.p_we    = 1'b0;
      bus_a.p_addr  = '0;
      bus_a.p_wdata = '0;
      bus_a.c_req   = 1'b0;
      bus_a.c_we    = 1'b0;
      bus_a.c_addr  = '0;
      bus_a.c_wdata = '0;

      // 1: reset with random requests
      for (int i = 0; i < 3; i++) begin
         bus_a.p_req = 1'($urandom_range(0, 1));
         bus_a.c_req = 1'($urandom_range(0, 1));
         bus_a.p_we  = 1'($urandom_range(0, 1));
         bus_a.c_we  = 1'($urandom_range(0, 1));
         tick();
      end
      chk("rst_busy_a",  bus_a.busy, 0);
      chk("rst_wren_a",  bus_a.wren, 0);
      chk("rst_pack_a",  bus_a.p_ack, 0);
      chk("rst_cack_a",  bus_a.c_ack, 0);
      chk("rst_owner_a", bus_a.owner, 0);
      chk("rst_addr_a",  bus_a.ram_address, 0);
      chk("rst_wdat_a",  bus_a.ram_data_O, 0);
      chk("rst_prd_a",   bus_a.p_rdata, 0);
      chk("rst_crd_a",   bus_a.c_rdata, 0);
      chk("rst_busy_b",  bus_b.busy, 0);
      chk("rst_wren_b",  bus_b.wren, 0);
      bus_a.p_req = 1'b0;
      bus_a.c_req = 1'b0;
      bus_a.p_we  = 1'b0;
      bus_a.c_we  = 1'b0;
      RSTN = 1'b1;
      tick();

      // 2: panel write 0010 <- BEEF
      bus_a.p_req   = 1'b1;
      bus_a.p_we    = 1'b1;
      bus_a.p_addr  = 16'h0010;
      bus_a.p_wdata = 16'hBEEF;
      chk("w_wren_pre", bus_a.wren, 0);
      tick();
      chk("w_wren_e0",  bus_a.wren, 1);
      chk("w_addr",     bus_a.ram_address, 16'h0010);
      chk("w_data",     bus_a.ram_data_O, 16'hBEEF);
      chk("w_busy",     bus_a.busy, 1);
      chk("w_owner",    bus_a.owner, 0);
      chk("w_pack_e0",  bus_a.p_ack, 0);
      tick();
      chk("w_wren_e1",  bus_a.wren, 0);
      chk("w_pack_e1",  bus_a.p_ack, 1);
      chk("w_cack_e1",  bus_a.c_ack, 0);
      bus_a.p_req = 1'b0;
      tick();
      chk("w_pack_e2",  bus_a.p_ack, 0);
      chk("w_busy_e2",  bus_a.busy, 0);
      chk("w_mem",      mem_a[8'h10], 16'hBEEF);

      // 3: CPU read of 0010 after the RAM model is loaded with 1234
      ld = 1'b1; ld_addr = 16'h0010; ld_data = 16'h1234;
      tick();
      ld = 1'b0;
      bus_a.c_req  = 1'b1;
      bus_a.c_we   = 1'b0;
      bus_a.c_addr = 16'h0010;
      tick();
      chk("r_busy",     bus_a.busy, 1);
      chk("r_owner",    bus_a.owner, 1);
      chk("r_wren",     bus_a.wren, 0);
      tick();
      chk("r_cack_e1",  bus_a.c_ack, 0);
      tick();
      chk("r_cack_e2",  bus_a.c_ack, 1);
      chk("r_crdata",   bus_a.c_rdata, 16'h1234);
      chk("r_prdata",   bus_a.p_rdata, 0);
      chk("r_pack",     bus_a.p_ack, 0);
      bus_a.c_req = 1'b0;
      tick();
      chk("r_cack_e3",  bus_a.c_ack, 0);
      chk("r_busy_e3",  bus_a.busy, 0);

      // 4: both requesters held for four transactions
      bus_a.p_req = 1'b1; bus_a.p_we = 1'b1; bus_a.p_addr = 16'h0020; bus_a.p_wdata = 16'hAAAA;
      bus_a.c_req = 1'b1; bus_a.c_we = 1'b1; bus_a.c_addr = 16'h0030; bus_a.c_wdata = 16'h5555;
      for (int k = 1; k <= 11; k++) begin
         tick();
         chk($sformatf("tie_pack_a_%0d", k), bus_a.p_ack, (k == 2 || k == 8) ? 1 : 0);
         chk($sformatf("tie_cack_a_%0d", k), bus_a.c_ack, (k == 5 || k == 11) ? 1 : 0);
         chk($sformatf("tie_pack_b_%0d", k), bus_b.p_ack, (k % 3 == 2) ? 1 : 0);
         chk($sformatf("tie_cack_b_%0d", k), bus_b.c_ack, 0);
         chk($sformatf("tie_busy_a_%0d", k), bus_a.busy, (k % 3 != 0) ? 1 : 0);
      end
      bus_a.p_req = 1'b0;
      bus_a.c_req = 1'b0;
      tick();
      chk("tie_busy_a_end", bus_a.busy, 0);
      chk("tie_busy_b_end", bus_b.busy, 0);
      tick();
      chk("tie_idle_a", bus_a.busy, 0);
      chk("tie_mem_c",  mem_a[8'h30], 16'h5555);
      chk("tie_mem_p",  mem_b[8'h20], 16'hAAAA);

      // 5: reset pulse in the middle of a panel read, then a re-issued read
      bus_a.p_req = 1'b1; bus_a.p_we = 1'b0; bus_a.p_addr = 16'h0030;
      tick();
      chk("rr_busy_pre", bus_a.busy, 1);
      #2 RSTN = 1'b0;
      #1;
      chk("rr_busy_rst", bus_a.busy, 0);
      chk("rr_pack_rst", bus_a.p_ack, 0);
      chk("rr_wren_rst", bus_a.wren, 0);
      bus_a.p_req = 1'b0;
      tick();
      RSTN = 1'b1;
      tick();
      chk("rr_pack_after", bus_a.p_ack, 0);
      chk("rr_busy_after", bus_a.busy, 0);
      bus_a.p_req = 1'b1;
      tick();
      chk("rr_busy_e0",  bus_a.busy, 1);
      tick();
      chk("rr_pack_e1",  bus_a.p_ack, 0);
      tick();
      chk("rr_pack_e2",  bus_a.p_ack, 1);
      chk("rr_prdata",   bus_a.p_rdata, 16'h5555);
      bus_a.p_req = 1'b0;
      tick();
      chk("rr_busy_end", bus_a.busy, 0);

      // 6: panel drops its request one cycle after the grant
      bus_a.p_req = 1'b1; bus_a.p_we = 1'b1; bus_a.p_addr = 16'h0040; bus_a.p_wdata = 16'h1357;
      tick();
      chk("dr_wren_e0", bus_a.wren, 1);
      bus_a.p_req = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (bus_a.p_ack) n_pack++;
      end
      chk("dr_ack_count", n_pack, 1);
      chk("dr_busy_end",  bus_a.busy, 0);
      chk("dr_mem",       mem_a[8'h40], 16'h1357);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
